// File: rtl/dm_ls_master.sv
// Load/store unit data-memory master: takes one pipeline load/store request,
// drives a single data-memory transfer and returns lane-extracted, extended load data.
module dm_ls_master #(
  parameter int unsigned DATA_BITS     = 32,
  parameter int unsigned AHB_SIZE_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ls_valid,
  input  logic                     ls_write,
  input  logic [AHB_SIZE_BITS-1:0] ls_size,
  input  logic                     ls_unsigned,
  input  logic [DATA_BITS-1:0]     ls_addr,
  input  logic [DATA_BITS-1:0]     ls_wdata,
  output logic                     ls_ready,
  output logic                     ls_done,
  output logic                     ls_err,
  output logic [DATA_BITS-1:0]     ls_rdata,
  output logic                     D_req,
  output logic                     D_write,
  output logic [AHB_SIZE_BITS-1:0] D_type,
  output logic [DATA_BITS-1:0]     D_addr,
  output logic [DATA_BITS-1:0]     D_in,
  input  logic [DATA_BITS-1:0]     D_out,
  input  logic                     D_wait
);

  localparam logic [AHB_SIZE_BITS-1:0] SIZE_BYTE  = AHB_SIZE_BITS'(0);
  localparam logic [AHB_SIZE_BITS-1:0] SIZE_HWORD = AHB_SIZE_BITS'(1);
  localparam logic [AHB_SIZE_BITS-1:0] SIZE_WORD  = AHB_SIZE_BITS'(2);
  localparam int unsigned SHIFT_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state, state_nx;
  logic                     req_unsigned, req_unsigned_nx;
  logic                     ls_ready_nx, ls_done_nx, ls_err_nx;
  logic [DATA_BITS-1:0]     ls_rdata_nx;
  logic                     d_req_nx, d_write_nx;
  logic [AHB_SIZE_BITS-1:0] d_type_nx;
  logic [DATA_BITS-1:0]     d_addr_nx, d_in_nx;

  logic                     req_legal_c;
  logic [SHIFT_BITS-1:0]    st_shift_c, ld_shift_c;
  logic [DATA_BITS-1:0]     st_data_c, st_lane_c;
  logic [DATA_BITS-1:0]     ld_raw_c, ld_ext_c;

  // Request legality and store-data lane placement
  always_comb begin
    st_shift_c = {ls_addr[1:0], 3'b000};
    unique case (ls_size)
      SIZE_BYTE: begin
        req_legal_c = 1'b1;
        st_data_c   = DATA_BITS'(ls_wdata[7:0]);
      end
      SIZE_HWORD: begin
        req_legal_c = ~ls_addr[0];
        st_data_c   = DATA_BITS'(ls_wdata[15:0]);
      end
      SIZE_WORD: begin
        req_legal_c = (ls_addr[1:0] == 2'b00);
        st_data_c   = ls_wdata;
      end
      default: begin
        req_legal_c = 1'b0;
        st_data_c   = '0;
      end
    endcase
    st_lane_c = st_data_c << st_shift_c;
  end

  // Load-data lane extraction and sign/zero extension from the held request
  always_comb begin
    ld_shift_c = {D_addr[1:0], 3'b000};
    ld_raw_c   = D_out >> ld_shift_c;
    unique case (D_type)
      SIZE_BYTE:  ld_ext_c = {{(DATA_BITS-8){ld_raw_c[7] & ~req_unsigned}}, ld_raw_c[7:0]};
      SIZE_HWORD: ld_ext_c = {{(DATA_BITS-16){ld_raw_c[15] & ~req_unsigned}}, ld_raw_c[15:0]};
      default:    ld_ext_c = D_out;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx        = state;
    req_unsigned_nx = req_unsigned;
    ls_err_nx       = 1'b0;
    ls_rdata_nx     = ls_rdata;
    d_write_nx      = 1'b0;
    d_type_nx       = D_type;
    d_addr_nx       = D_addr;
    d_in_nx         = D_in;

    unique case (state)
      IDLE: begin
        if (ls_valid) begin
          if (req_legal_c) begin
            state_nx        = REQ;
            req_unsigned_nx = ls_unsigned;
            d_write_nx      = ls_write;
            d_type_nx       = ls_size;
            d_addr_nx       = ls_addr;
            d_in_nx         = st_lane_c;
          end else begin
            state_nx    = RESP;
            ls_err_nx   = 1'b1;
            ls_rdata_nx = '0;
          end
        end
      end
      REQ: begin
        if (D_wait) begin
          d_write_nx = D_write;
        end else begin
          state_nx    = RESP;
          ls_rdata_nx = D_write ? '0 : ld_ext_c;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    ls_ready_nx = (state_nx == IDLE);
    ls_done_nx  = (state_nx == RESP);
    d_req_nx    = (state_nx == REQ);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_unsigned <= 1'b0;
      ls_ready     <= 1'b1;
      ls_done      <= 1'b0;
      ls_err       <= 1'b0;
      ls_rdata     <= '0;
      D_req        <= 1'b0;
      D_write      <= 1'b0;
      D_type       <= '0;
      D_addr       <= '0;
      D_in         <= '0;
    end else begin
      state        <= state_nx;
      req_unsigned <= req_unsigned_nx;
      ls_ready     <= ls_ready_nx;
      ls_done      <= ls_done_nx;
      ls_err       <= ls_err_nx;
      ls_rdata     <= ls_rdata_nx;
      D_req        <= d_req_nx;
      D_write      <= d_write_nx;
      D_type       <= d_type_nx;
      D_addr       <= d_addr_nx;
      D_in         <= d_in_nx;
    end
  end

endmodule

// File: tb/tb_dm_ls_master.sv
// Self-checking bench for dm_ls_master: directed corner transactions plus
// randomized loads/stores checked against a lane-arithmetic reference model.
module tb_dm_ls_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_valid, ls_write, ls_unsigned;
  logic [2:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_ready, ls_done, ls_err;
  logic [31:0] ls_rdata;
  logic        D_req, D_write;
  logic [2:0]  D_type;
  logic [31:0] D_addr, D_in, D_out;
  logic        D_wait;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  dm_ls_master #(.DATA_BITS(32), .AHB_SIZE_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .D_req(D_req), .D_write(D_write), .D_type(D_type), .D_addr(D_addr),
    .D_in(D_in), .D_out(D_out), .D_wait(D_wait)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a request is legal when its address is a multiple of its byte count
  function automatic logic model_legal(input logic [2:0] sz, input logic [31:0] addr);
    int unsigned nbytes;
    if (sz > 3'd2) return 1'b0;
    nbytes = 1 << sz;
    return (addr % nbytes) == 0;
  endfunction

  function automatic logic [31:0] model_din(input logic [2:0] sz, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    longint unsigned mask, val;
    int unsigned off;
    off  = addr % 4;
    mask = (64'd1 << (8 * (1 << sz))) - 1;
    val  = (64'(wdata) & mask) * (64'd1 << (8 * off));
    return 32'(val);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] sz, input logic uns,
                                              input logic [31:0] addr, input logic [31:0] dout);
    longint unsigned mask, val, sign;
    int unsigned off, nbits;
    off   = addr % 4;
    nbits = 8 * (1 << sz);
    mask  = (64'd1 << nbits) - 1;
    val   = (64'(dout) / (64'd1 << (8 * off))) & mask;
    sign  = 64'd1 << (nbits - 1);
    if (!uns && (val & sign) != 0) val = val + (64'hFFFF_FFFF - mask);
    return 32'(val);
  endfunction

  task automatic run_txn(input logic wr, input logic [2:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] dout, input int waits);
    logic        legal;
    logic [31:0] e_din, e_rd;
    legal = model_legal(sz, addr);
    e_din = model_din(sz, addr, wdata);
    e_rd  = wr ? 32'h0 : model_rdata(sz, uns, addr, dout);
    check("ready_idle", 32'(ls_ready), 32'd1);
    ls_valid = 1'b1; ls_write = wr; ls_size = sz; ls_unsigned = uns;
    ls_addr = addr; ls_wdata = wdata;
    @(posedge clk); #1;
    ls_valid = 1'b0; ls_write = 1'($urandom); ls_size = 3'($urandom);
    ls_unsigned = 1'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
    if (!legal) begin
      check("err_done", 32'(ls_done), 32'd1);
      check("err_flag", 32'(ls_err), 32'd1);
      check("err_rdata", ls_rdata, 32'h0);
      check("err_no_dreq", 32'(D_req), 32'd0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        check("dreq", 32'(D_req), 32'd1);
        check("dwrite", 32'(D_write), 32'(wr));
        check("dtype", 32'(D_type), 32'(sz));
        check("daddr", D_addr, addr);
        check("din", D_in, e_din);
        check("no_done_req", 32'(ls_done), 32'd0);
        check("not_ready_req", 32'(ls_ready), 32'd0);
        D_wait   = (w < waits);
        D_out    = (w < waits) ? $urandom : dout;
        ls_valid = (w < waits) ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
      end
      D_wait = 1'($urandom);
      D_out  = $urandom;
      check("done", 32'(ls_done), 32'd1);
      check("ok_err", 32'(ls_err), 32'd0);
      check("rdata", ls_rdata, e_rd);
      check("dreq_low_resp", 32'(D_req), 32'd0);
      check("dwrite_low_resp", 32'(D_write), 32'd0);
    end
    @(posedge clk); #1;
    D_wait = 1'b0;
    check("done_one_cycle", 32'(ls_done), 32'd0);
    check("ready_back", 32'(ls_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] addr;
    rst_n = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; ls_size = 3'd0; ls_unsigned = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0; D_out = 32'h0; D_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dreq", 32'(D_req), 32'd0);
    check("rst_dwrite", 32'(D_write), 32'd0);
    check("rst_done", 32'(ls_done), 32'd0);
    check("rst_err", 32'(ls_err), 32'd0);
    check("rst_rdata", ls_rdata, 32'h0);
    check("rst_daddr", D_addr, 32'h0);
    check("rst_din", D_in, 32'h0);
    check("rst_dtype", 32'(D_type), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ls_ready), 32'd1);

    run_txn(1'b0, 3'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFF12, 0);
    run_txn(1'b1, 3'd1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0);
    run_txn(1'b0, 3'd2, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5);
    run_txn(1'b0, 3'd2, 1'b0, 32'h41, 32'h0, 32'h0, 0);
    run_txn(1'b1, 3'd1, 1'b0, 32'h43, 32'h1234, 32'h0, 0);
    run_txn(1'b0, 3'd3, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    run_txn(1'b0, 3'd1, 1'b1, 32'h2, 32'h0, 32'h80010000, 0);
    run_txn(1'b0, 3'd1, 1'b0, 32'h2, 32'h0, 32'h80010000, 1);

    // Reset mid-transfer while the memory is stalling
    ls_valid = 1'b1; ls_write = 1'b0; ls_size = 3'd2; ls_addr = 32'h80; ls_unsigned = 1'b0;
    @(posedge clk); #1;
    ls_valid = 1'b0; D_wait = 1'b1;
    @(posedge clk); #1;
    check("abort_dreq_pre", 32'(D_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_dreq", 32'(D_req), 32'd0);
    check("abort_done", 32'(ls_done), 32'd0);
    check("abort_daddr", D_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1; D_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(ls_done), 32'd0);
      check("abort_ready", 32'(ls_ready), 32'd1);
    end
    run_txn(1'b1, 3'd0, 1'b0, 32'h7, 32'h000000A5, 32'h0, 2);

    for (int t = 0; t < 60; t++) begin
      sz   = 3'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) addr = addr & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
